// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04 class ultrasonic ranger controller.
// Fires a periodic trigger pulse, times the synchronised echo and publishes
// a 32-bit word {valid, timeout, seq[5:0], 2'b00, width[21:0]} with a strobe.
// Optional build macro SONAR_AVG_EN: width field carries the mean of the
// last four non-timeout widths instead of the raw width.
module sonar_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int PERIOD_CYCLES  = 3000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [31:0] sonar_export,
    output logic        sample_strobe
);
    localparam int PER_W  = $clog2(PERIOD_CYCLES);
    localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);

    localparam logic [21:0]       WIDTH_MAX = 22'h3F_FFFF;
    localparam logic [21:0]       TO_LAST   = 22'(TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_PUBLISH   = 3'd4;

    logic [2:0]        state;
    logic              first_pending;
    logic [PER_W-1:0]  per_cnt;
    logic [TRIG_W-1:0] trig_cnt;
    logic [21:0]       to_cnt;
    logic [21:0]       to_next;
    logic              to_hit;
    logic [21:0]       width;
    logic              timed_out;
    logic [5:0]        seq;
    logic [21:0]       pub_width;
    logic              start_trig;

    logic echo_meta, echo_sync, echo_prev;
    logic echo_rise, echo_fall;

    // two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
        end
    end

    assign echo_rise  = echo_sync & ~echo_prev;
    assign echo_fall  = ~echo_sync & echo_prev;
    assign to_next    = to_cnt + 22'd1;
    assign to_hit     = (to_next == TO_LAST);
    assign start_trig = (state == S_IDLE) && enable &&
                        (first_pending || (per_cnt == PER_LAST));

    // period counter: restarts at each trigger, then saturates so IDLE can fire
    always_ff @(posedge clk) begin
        if (!reset_n)
            per_cnt <= '0;
        else if (start_trig)
            per_cnt <= '0;
        else if (per_cnt != PER_LAST)
            per_cnt <= per_cnt + 1'b1;
    end

    // ranging FSM: trigger, wait for echo, measure, publish
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            trig          <= 1'b0;
            first_pending <= 1'b1;
            trig_cnt      <= '0;
            to_cnt        <= '0;
            width         <= '0;
            timed_out     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_trig) begin
                        state         <= S_TRIG;
                        trig          <= 1'b1;
                        trig_cnt      <= '0;
                        first_pending <= 1'b0;
                    end
                end
                S_TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        state  <= S_WAIT_RISE;
                        trig   <= 1'b0;
                        to_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                S_WAIT_RISE: begin
                    to_cnt <= to_next;
                    if (to_hit) begin
                        timed_out <= 1'b1;
                        width     <= WIDTH_MAX;
                        state     <= S_PUBLISH;
                    end else if (echo_rise) begin
                        width <= 22'd1;
                        state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    to_cnt <= to_next;
                    // timeout outranks a coincident falling edge
                    if (to_hit) begin
                        timed_out <= 1'b1;
                        width     <= WIDTH_MAX;
                        state     <= S_PUBLISH;
                    end else if (echo_fall) begin
                        timed_out <= 1'b0;
                        state     <= S_PUBLISH;
                    end else if (echo_sync && (width != WIDTH_MAX)) begin
                        width <= width + 22'd1;
                    end
                end
                S_PUBLISH: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef SONAR_AVG_EN
    logic [21:0] hist [3];   // three most recent good widths, [0] newest
    logic [1:0]  hist_cnt;   // how many history entries hold real samples
    logic [21:0] avg_q;      // last published average, reused on timeout
    logic [23:0] sum;
    logic [21:0] mean;

    // mean over the new width plus up to three prior good widths;
    // unused history slots are zero so a plain four-way sum is safe
    always_comb begin
        sum = 24'(width) + 24'(hist[0]) + 24'(hist[1]) + 24'(hist[2]);
        case (hist_cnt)
            2'd0:    mean = width;
            2'd1:    mean = 22'(sum >> 1);
            2'd2:    mean = 22'((40'(sum) * 40'd21845) >> 16);
            default: mean = 22'(sum >> 2);
        endcase
        pub_width = timed_out ? avg_q : mean;
    end

    // history shifts only on good measurements
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist[0]  <= '0;
            hist[1]  <= '0;
            hist[2]  <= '0;
            hist_cnt <= '0;
            avg_q    <= '0;
        end else if ((state == S_PUBLISH) && !timed_out) begin
            hist[0] <= width;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            avg_q   <= mean;
            if (hist_cnt != 2'd3)
                hist_cnt <= hist_cnt + 2'd1;
        end
    end
`else
    assign pub_width = width;
`endif

    // output word and strobe update together; word holds between publishes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sonar_export  <= '0;
            sample_strobe <= 1'b0;
            seq           <= '0;
        end else begin
            sample_strobe <= 1'b0;
            if (state == S_PUBLISH) begin
                sonar_export  <= {1'b1, timed_out, seq, 2'b00, pub_width};
                sample_strobe <= 1'b1;
                seq           <= seq + 6'd1;
            end
        end
    end

endmodule
